// File: rtl/sign_mag_convert_serial_if.sv
// Request/result bundle for the serial sign/magnitude converter.
// The requester uses the master modport; the converter uses the slave modport.
interface sign_mag_convert_serial_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             mode;
  logic             sign_in;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic             sign;
  logic [WIDTH-1:0] dout;
  logic             ovf;

  modport master (
    output start, mode, sign_in, din,
    input  busy, done, sign, dout, ovf
  );

  modport slave (
    input  start, mode, sign_in, din,
    output busy, done, sign, dout, ovf
  );
endinterface

// File: rtl/sign_mag_convert_serial.sv
// Multi-cycle sign/magnitude <-> two's complement converter.
// mode 0: two's complement -> sign + magnitude; mode 1: sign + magnitude -> two's complement.
// The negation (~x + 1) is computed CHUNK bits per cycle, LSB chunk first,
// so every conversion takes WIDTH/CHUNK cycles in CONV, then one cycle in DONE.
// Optional feature macro: SM_CONV_SAT_EN -- saturate dout on mode-1 overflow.
module sign_mag_convert_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  sign_mag_convert_serial_if.slave bus
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef SM_CONV_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("sign_mag_convert_serial: WIDTH must be a multiple of CHUNK");
    end
    if (WIDTH < 4) begin : g_bad_width
      $error("sign_mag_convert_serial: WIDTH must be at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] din_q;
  logic             mode_q;
  logic             sign_in_q;
  logic [WIDTH-1:0] neg_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] dout_q;
  logic             sign_q;
  logic             ovf_q;

  logic [CHUNK-1:0] x_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] neg_full;
  logic             last_chunk;
  logic             neg_res;
  logic [WIDTH-1:0] res_dout;
  logic             res_sign;
  logic             res_ovf;

  // One chunk of ~x + carry; neg_full already includes the chunk being
  // produced this cycle, so the final edge can register a complete result.
  always_comb begin
    x_chunk    = din_q[idx_q*CHUNK +: CHUNK];
    chunk_sum  = {1'b0, ~x_chunk} + (CHUNK+1)'(carry_q);
    neg_full   = neg_q;
    neg_full[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    last_chunk = (idx_q == IDX_W'(N - 1));
  end

  // Result selection for both modes, including overflow and optional saturation.
  always_comb begin
    neg_res  = 1'b0;
    res_dout = din_q;
    res_sign = 1'b0;
    res_ovf  = 1'b0;
    if (!mode_q) begin
      res_sign = din_q[WIDTH-1];
      res_dout = din_q[WIDTH-1] ? neg_full : din_q;
    end else begin
      neg_res  = sign_in_q && (din_q != '0);
      res_sign = neg_res;
      res_dout = neg_res ? neg_full : din_q;
      res_ovf  = (neg_res && (din_q > MSB_ONLY)) ||
                 (!sign_in_q && (din_q >= MSB_ONLY));
`ifdef SM_CONV_SAT_EN
      if (res_ovf) begin
        res_dout = neg_res ? MSB_ONLY : MAX_POS;
      end
`endif
    end
  end

  // Control FSM, operand latch, chunk carry chain and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      din_q     <= '0;
      mode_q    <= 1'b0;
      sign_in_q <= 1'b0;
      neg_q     <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      dout_q    <= '0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            din_q     <= bus.din;
            mode_q    <= bus.mode;
            sign_in_q <= bus.sign_in;
            neg_q     <= '0;
            carry_q   <= 1'b1;
            idx_q     <= '0;
            state_q   <= CONV;
          end else begin
            state_q   <= IDLE;
          end
        end
        CONV: begin
          neg_q   <= neg_full;
          carry_q <= chunk_sum[CHUNK];
          idx_q   <= idx_q + IDX_W'(1);
          if (last_chunk) begin
            dout_q  <= res_dout;
            sign_q  <= res_sign;
            ovf_q   <= res_ovf;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q == CONV);
  assign bus.done = (state_q == DONE);
  assign bus.dout = dout_q;
  assign bus.sign = sign_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_sign_mag_convert_serial.sv
// Directed bench for sign_mag_convert_serial at WIDTH=16, CHUNK=4.
// Expected values are hand-computed; SM_CONV_SAT_EN selects the saturated expectations.
module tb_sign_mag_convert_serial;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc_cnt;
  int   done_cyc;

  sign_mag_convert_serial_if #(.WIDTH(WIDTH)) bus ();

  sign_mag_convert_serial #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used to measure done-to-done spacing.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge and wait for its done pulse; returns at
  // the negedge where done is observed high.
  task automatic do_conv(input string tag, input logic m, input logic s, input logic [15:0] d,
                         input logic [15:0] e_dout, input logic e_sign, input logic e_ovf);
    int busy_n;
    int waited;
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.sign_in = s;
    bus.din     = d;
    @(negedge clk);
    bus.start = 1'b0;
    busy_n = 0;
    waited = 0;
    while (!bus.done && waited < 20) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      waited++;
    end
    done_cyc = cyc_cnt;
    check_eq({tag, "_done"},  32'(bus.done), 32'd1);
    check_eq({tag, "_busyn"}, 32'(busy_n), 32'd4);
    check_eq({tag, "_bsydn"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_dout"},  32'(bus.dout), 32'(e_dout));
    check_eq({tag, "_sign"},  32'(bus.sign), 32'(e_sign));
    check_eq({tag, "_ovf"},   32'(bus.ovf),  32'(e_ovf));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_sign"}, 32'(bus.sign), 32'd0);
    check_eq({tag, "_ovf"},  32'(bus.ovf),  32'd0);
    check_eq({tag, "_dout"}, 32'(bus.dout), 32'd0);
  endtask

  initial begin
    int seen;
    int prev_done;
    checks      = 0;
    errors      = 0;
    cyc_cnt     = 0;
    done_cyc    = 0;
    rst_n       = 1'b1;
    bus.start   = 1'b0;
    bus.mode    = 1'b0;
    bus.sign_in = 1'b0;
    bus.din     = '0;

    // Reset state and quiet idle.
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check_eq("idle_quiet", 32'(seen), 32'd0);

    // Mode 0: two's complement -> sign/magnitude.
    do_conv("m0_neg10", 1'b0, 1'b0, 16'hFFF6, 16'h000A, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("m0_done_1cyc", 32'(bus.done), 32'd0);
    check_eq("m0_hold_dout", 32'(bus.dout), 32'h000A);
    do_conv("m0_pos", 1'b0, 1'b0, 16'h007B, 16'h007B, 1'b0, 1'b0);
    @(negedge clk);
    do_conv("m0_min", 1'b0, 1'b0, 16'h8000, 16'h8000, 1'b1, 1'b0);
    @(negedge clk);
    do_conv("m0_sgnign", 1'b0, 1'b1, 16'h0005, 16'h0005, 1'b0, 1'b0);
    @(negedge clk);

    // Mode 1: sign/magnitude -> two's complement.
    do_conv("m1_negzero", 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    do_conv("m1_neg10", 1'b1, 1'b1, 16'h000A, 16'hFFF6, 1'b1, 1'b0);
    @(negedge clk);
    do_conv("m1_negmin", 1'b1, 1'b1, 16'h8000, 16'h8000, 1'b1, 1'b0);
    @(negedge clk);
    do_conv("m1_posmax", 1'b1, 1'b0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    @(negedge clk);
`ifdef SM_CONV_SAT_EN
    do_conv("m1_negovf", 1'b1, 1'b1, 16'h8001, 16'h8000, 1'b1, 1'b1);
    @(negedge clk);
    do_conv("m1_posovf", 1'b1, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
`else
    do_conv("m1_negovf", 1'b1, 1'b1, 16'h8001, 16'h7FFF, 1'b1, 1'b1);
    @(negedge clk);
    do_conv("m1_posovf", 1'b1, 1'b0, 16'h8000, 16'h8000, 1'b0, 1'b1);
`endif
    @(negedge clk);

    // Start while busy is ignored: only the FFFF request completes.
    bus.start = 1'b1; bus.mode = 1'b0; bus.sign_in = 1'b0; bus.din = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.din = 16'h0001;
    @(negedge clk);
    bus.start = 1'b0; bus.din = 16'h0000;
    seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (bus.done) begin
        seen++;
        check_eq("busy_ign_dout", 32'(bus.dout), 32'h0001);
        check_eq("busy_ign_sign", 32'(bus.sign), 32'd1);
      end
    end
    check_eq("busy_ign_ndone", 32'(seen), 32'd1);

    // Start accepted in the DONE cycle: one result every N+1 cycles.
    do_conv("b2b_a", 1'b0, 1'b0, 16'hFFFE, 16'h0002, 1'b1, 1'b0);
    prev_done = done_cyc;
    do_conv("b2b_b", 1'b1, 1'b1, 16'h1234, 16'hEDCC, 1'b1, 1'b0);
    check_eq("b2b_gap", 32'(done_cyc - prev_done), 32'd5);
    @(negedge clk);

    // Asynchronous reset in the middle of a conversion.
    bus.start = 1'b1; bus.mode = 1'b1; bus.sign_in = 1'b1; bus.din = 16'h0003;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", 32'(bus.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check_eq("midrst_nodone", 32'(seen), 32'd0);
    do_conv("after_rst", 1'b1, 1'b1, 16'h0003, 16'hFFFD, 1'b1, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
